// File: rtl/simon_arbiter.sv
// simon_arbiter: round-robin scheduler sharing one SIMON_3264 core between two requesters.
// Optional key-reuse shortcut is compiled in when SIMON_KEY_REUSE_EN is defined.
module simon_arbiter #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_enc_dec,
  input  logic [1:0][2*N-1:0]   req_block,
  input  logic [1:0][M*N-1:0]   req_key,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [2*N-1:0]        rsp_data,
  output logic                  busy,
  output logic                  newKey,
  output logic                  newData,
  output logic                  readData,
  output logic                  enc_dec,
  output logic [M*N-1:0]        key,
  output logic [2*N-1:0]        plain,
  input  logic                  ldKey,
  input  logic                  doneKey,
  input  logic                  ldData,
  input  logic                  doneData,
  input  logic [2*N-1:0]        cipher
);

  typedef enum logic [2:0] {
    IDLE, GRANT, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, READ, RESP
  } state_t;

  state_t state, state_nxt;
  logic   gnt, gnt_nxt;
  logic   rr;
  logic   key_owner_valid;
  logic   key_match;
  logic   skip_key;

`ifdef SIMON_KEY_REUSE_EN
  logic [M*N-1:0] last_key;

  // Remember the key most recently expanded by the core.
  always_ff @(posedge clk) begin
    if (R) begin
      last_key <= {(M*N){1'b0}};
    end else if (state == KEY_WAIT && doneKey) begin
      last_key <= key;
    end
  end

  assign key_match = (key == last_key);
`else
  assign key_match = 1'b0;
`endif

  assign skip_key = key_owner_valid & key_match;

  // Next-state and grant selection.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          state_nxt = GRANT;
          if (req_valid == 2'b11) begin
            gnt_nxt = rr;
          end else begin
            gnt_nxt = req_valid[1];
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (skip_key) begin
          state_nxt = DATA_REQ;
        end else begin
          state_nxt = KEY_REQ;
        end
      end
      KEY_REQ: begin
        if (ldKey) state_nxt = KEY_WAIT;
        else       state_nxt = KEY_REQ;
      end
      KEY_WAIT: begin
        if (doneKey) state_nxt = DATA_REQ;
        else         state_nxt = KEY_WAIT;
      end
      DATA_REQ: begin
        if (ldData) state_nxt = DATA_WAIT;
        else        state_nxt = DATA_REQ;
      end
      DATA_WAIT: begin
        if (doneData) state_nxt = READ;
        else          state_nxt = DATA_WAIT;
      end
      READ: begin
        if (!doneData) state_nxt = RESP;
        else           state_nxt = READ;
      end
      RESP: begin
        if (rsp_ready[gnt]) state_nxt = IDLE;
        else                state_nxt = RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath latches and outputs; outputs are decoded from the next state so they
  // line up with the state they belong to while still coming straight from flops.
  always_ff @(posedge clk) begin
    if (R) begin
      state           <= IDLE;
      gnt             <= 1'b0;
      rr              <= 1'b0;
      key_owner_valid <= 1'b0;
      req_ready       <= 2'b00;
      rsp_valid       <= 2'b00;
      rsp_data        <= {(2*N){1'b0}};
      busy            <= 1'b0;
      newKey          <= 1'b0;
      newData         <= 1'b0;
      readData        <= 1'b0;
      enc_dec         <= 1'b0;
      key             <= {(M*N){1'b0}};
      plain           <= {(2*N){1'b0}};
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      req_ready <= (state_nxt == GRANT) ? {gnt_nxt, ~gnt_nxt} : 2'b00;
      rsp_valid <= (state_nxt == RESP)  ? {gnt_nxt, ~gnt_nxt} : 2'b00;
      busy      <= (state_nxt != IDLE);
      newKey    <= (state_nxt == KEY_REQ);
      newData   <= (state_nxt == DATA_REQ);
      readData  <= (state_nxt == READ);
      if (state == IDLE && state_nxt == GRANT) begin
        key     <= req_key[gnt_nxt];
        plain   <= req_block[gnt_nxt];
        enc_dec <= req_enc_dec[gnt_nxt];
      end
      if (state == DATA_WAIT && doneData) begin
        rsp_data <= cipher;
      end
      if (state == KEY_WAIT && doneKey) begin
        key_owner_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready[gnt]) begin
        rr <= ~gnt;
      end
    end
  end

endmodule

// File: tb/tb_simon_arbiter.sv
// Table-driven bench for simon_arbiter with a behavioural stand-in for the SIMON_3264 handshakes.
module tb_simon_arbiter;

  localparam logic [31:0] XORC = 32'hA3FE81CC;
  localparam logic [63:0] K1   = 64'h1918111009080100;
  localparam logic [63:0] K2   = 64'h0123456789ABCDEF;
  localparam int LD_DLY  = 2;
  localparam int KROUNDS = 4;
  localparam int DROUNDS = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             R;
  logic [1:0]       req_valid, req_ready, req_enc_dec, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_block;
  logic [1:0][63:0] req_key;
  logic [31:0]      rsp_data, plain, cipher;
  logic             busy, newKey, newData, readData, enc_dec;
  logic [63:0]      key;
  logic             ldKey, doneKey, ldData, doneData;

  simon_arbiter #(.N(16), .M(4)) dut (
    .clk(clk), .R(R),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc_dec(req_enc_dec),
    .req_block(req_block), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .newKey(newKey), .newData(newData), .readData(readData),
    .enc_dec(enc_dec), .key(key), .plain(plain),
    .ldKey(ldKey), .doneKey(doneKey), .ldData(ldData), .doneData(doneData),
    .cipher(cipher)
  );

  int checks = 0;
  int errors = 0;

  // Core stand-in: ldKey/ldData only after the request has been held LD_DLY+1 cycles,
  // doneData held until readData is seen plus dd_hold extra cycles.
  int          kph, dph, kcnt, dcnt, hcnt;
  int          dd_hold = 0;
  int          key_loads = 0;
  int          overlap_err = 0;
  logic [63:0] loaded_key;
  logic [31:0] data_plain;
  logic        data_enc;

  always @(posedge clk) begin
    if (R) begin
      ldKey <= 1'b0; doneKey <= 1'b0; ldData <= 1'b0; doneData <= 1'b0;
      cipher <= 32'h0; kph <= 0; dph <= 0; kcnt <= 0; dcnt <= 0; hcnt <= 0;
    end else begin
      ldKey <= 1'b0; doneKey <= 1'b0; ldData <= 1'b0;
      if ((newKey && newData) || (newData && kph != 0)) overlap_err <= overlap_err + 1;
      case (kph)
        0: begin
          if (!newKey) kcnt <= 0;
          else if (kcnt == LD_DLY) begin
            ldKey <= 1'b1; kph <= 1; kcnt <= 0;
            key_loads <= key_loads + 1; loaded_key <= key;
          end else kcnt <= kcnt + 1;
        end
        1: begin
          if (kcnt == KROUNDS) begin doneKey <= 1'b1; kph <= 0; kcnt <= 0; end
          else kcnt <= kcnt + 1;
        end
        default: kph <= 0;
      endcase
      case (dph)
        0: begin
          if (!newData) dcnt <= 0;
          else if (dcnt == LD_DLY) begin
            ldData <= 1'b1; dph <= 1; dcnt <= 0;
            data_plain <= plain; data_enc <= enc_dec;
          end else dcnt <= dcnt + 1;
        end
        1: begin
          if (dcnt == DROUNDS) begin
            doneData <= 1'b1; cipher <= data_plain ^ XORC; dph <= 2; dcnt <= 0; hcnt <= 0;
          end else dcnt <= dcnt + 1;
        end
        2: begin
          if (readData) begin
            if (hcnt == dd_hold) begin doneData <= 1'b0; dph <= 0; end
            else hcnt <= hcnt + 1;
          end
        end
        default: dph <= 0;
      endcase
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic enc, input logic [63:0] k, input logic [31:0] blk);
    req_valid[p] = 1'b1; req_enc_dec[p] = enc; req_key[p] = k; req_block[p] = blk;
  endtask

  // Wait for grant of port p, then for its response, then accept it.
  task automatic serve(input int p, input logic [31:0] exp, input string nm);
    int cyc;
    logic [1:0] oh;
    oh = (p == 1) ? 2'b10 : 2'b01;
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 200) begin @(negedge clk); cyc++; end
    check({nm, " grant"}, {126'd0, req_ready}, {126'd0, oh});
    req_valid[p] = 1'b0;
    @(negedge clk);
    check({nm, " ready pulse"}, {126'd0, req_ready}, 128'd0);
    cyc = 0;
    while (rsp_valid == 2'b00 && cyc < 300) begin @(negedge clk); cyc++; end
    check({nm, " rsp_valid"}, {126'd0, rsp_valid}, {126'd0, oh});
    check({nm, " rsp_data"}, {96'd0, rsp_data}, {96'd0, exp});
    rsp_ready[p] = 1'b1;
    @(negedge clk);
    rsp_ready[p] = 1'b0;
    check({nm, " release"}, {125'd0, rsp_valid, busy}, 128'd0);
  endtask

  typedef struct {
    int          port;
    logic        enc;
    logic [63:0] k;
    logic [31:0] blk;
    logic [31:0] exp;
    int          loads;
    int          loads_reuse;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int loads0, exp_loads, cyc, cnt;
    R = 1'b1; req_valid = 2'b00; req_enc_dec = 2'b00; rsp_ready = 2'b00;
    req_block = '0; req_key = '0;
    repeat (2) @(negedge clk);
    check("reset ctrl", {121'd0, req_ready, rsp_valid, busy, newKey, newData, readData, enc_dec}, 128'd0);
    check("reset data", {rsp_data, key, plain}, 128'd0);
    R = 1'b0;

    vecs[0] = '{0, 1'b1, K1, 32'h65656877, 32'hC69BE9BB, 1, 1};
    vecs[1] = '{1, 1'b0, K1, 32'hC69BE9BB, 32'h65656877, 1, 0};
    vecs[2] = '{0, 1'b1, K2, 32'h00000000, 32'hA3FE81CC, 1, 1};
    vecs[3] = '{1, 1'b0, K2, 32'hFFFFFFFF, 32'h5C017E33, 1, 0};

    for (int i = 0; i < 4; i++) begin
      loads0 = key_loads;
`ifdef SIMON_KEY_REUSE_EN
      exp_loads = vecs[i].loads_reuse;
`else
      exp_loads = vecs[i].loads;
`endif
      @(negedge clk);
      drive(vecs[i].port, vecs[i].enc, vecs[i].k, vecs[i].blk);
      serve(vecs[i].port, vecs[i].exp, $sformatf("vec%0d", i));
      check($sformatf("vec%0d key loads", i), 128'(key_loads - loads0), 128'(exp_loads));
      check($sformatf("vec%0d enc_dec", i), {127'd0, data_enc}, {127'd0, vecs[i].enc});
      if (exp_loads > 0) check($sformatf("vec%0d key", i), {64'd0, loaded_key}, {64'd0, vecs[i].k});
    end

    // Simultaneous requests from reset: port0, port1, then port0 again.
    @(negedge clk); R = 1'b1; @(negedge clk); R = 1'b0;
    drive(0, 1'b1, K1, 32'h65656877);
    drive(1, 1'b1, K1, 32'h00000000);
    serve(0, 32'hC69BE9BB, "rr first");
    serve(1, 32'hA3FE81CC, "rr second");
    drive(0, 1'b1, K1, 32'h65656877);
    drive(1, 1'b1, K1, 32'h00000000);
    serve(0, 32'hC69BE9BB, "rr third");
    serve(1, 32'hA3FE81CC, "rr fourth");

    // Response back-pressure: port0 holds, port1 waits, foreign rsp_ready ignored.
    @(negedge clk);
    drive(0, 1'b1, K1, 32'h65656877);
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 200) begin @(negedge clk); cyc++; end
    req_valid[0] = 1'b0;
    cyc = 0;
    while (rsp_valid == 2'b00 && cyc < 300) begin @(negedge clk); cyc++; end
    drive(1, 1'b0, K2, 32'h00000000);
    rsp_ready[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("hold cycle %0d", i), {94'd0, rsp_valid, req_ready, rsp_data},
            {94'd0, 2'b01, 2'b00, 32'hC69BE9BB});
    end
    rsp_ready[1] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    check("hold release", {126'd0, rsp_valid}, 128'd0);
    serve(1, 32'hA3FE81CC, "after hold");

    // Reset during DATA_WAIT, then a fresh request with a full key load.
    @(negedge clk);
    drive(0, 1'b1, K1, 32'h65656877);
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 200) begin @(negedge clk); cyc++; end
    req_valid[0] = 1'b0;
    cyc = 0;
    while (!ldData && cyc < 200) begin @(negedge clk); cyc++; end
    @(negedge clk);
    R = 1'b1;
    @(negedge clk);
    R = 1'b0;
    check("abort ctrl", {121'd0, req_ready, rsp_valid, busy, newKey, newData, readData, enc_dec}, 128'd0);
    check("abort data", {rsp_data, key, plain}, 128'd0);
    loads0 = key_loads;
    @(negedge clk);
    drive(0, 1'b1, K1, 32'h65656877);
    serve(0, 32'hC69BE9BB, "post abort");
    check("post abort loads", 128'(key_loads - loads0), 128'd1);

    // doneData held 3 extra cycles: readData spans 5 cycles, rsp_valid right after.
    dd_hold = 3;
    @(negedge clk);
    drive(0, 1'b1, K2, 32'hFFFFFFFF);
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 200) begin @(negedge clk); cyc++; end
    req_valid[0] = 1'b0;
    cyc = 0;
    while (!readData && cyc < 300) begin @(negedge clk); cyc++; end
    cnt = 0;
    while (readData && cnt < 20) begin cnt++; @(negedge clk); end
    check("readData width", 128'(cnt), 128'd5);
    check("rsp after read", {94'd0, rsp_valid, rsp_data}, {94'd0, 2'b01, 32'h5C017E33});
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    dd_hold = 0;

    check("handshake overlap", 128'(overlap_err), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_arbiter.md
Name: simon_arbiter

Overview:
- Two-requester scheduler that shares one SIMON_3264 core.
- Accepts block requests (key, block, direction) on two ports and arbitrates round-robin.
- Drives the core's newKey/ldKey/doneKey and newData/ldData/doneData/readData handshakes, captures the result, and returns it to the granted requester.
- Sits between the bus-side requesters and the SIMON_3264 instance.

Parameters:
N, 16, word width; block is 2*N bits
M, 4, key words; key is M*N bits

Ports:
clk  in  1  system clock, all logic on rising edge
R  in  1  synchronous active-high reset
req_valid  in  2  per-port request valid
req_ready  out  2  per-port one-cycle accept pulse
req_enc_dec  in  2  per-port direction, 1=encrypt 0=decrypt
req_block  in  2x(2*N)  per-port input block
req_key  in  2x(M*N)  per-port key
rsp_valid  out  2  per-port result valid
rsp_ready  in  2  per-port result accept
rsp_data  out  2*N  result block, shared, qualified by rsp_valid
busy  out  1  high in every state except IDLE
newKey, newData, readData, enc_dec  out  1 each  to core
key  out  M*N  to core
plain  out  2*N  to core
ldKey, doneKey, ldData, doneData  in  1 each  from core
cipher  in  2*N  from core

Behaviour:
- Reset (R=1 at a clk edge):
  - state=IDLE; all outputs 0; rr pointer selects port 0.
  - key_owner_valid=0. R mid-operation aborts immediately.
  - The core's own reset is tied to ~R at the top level.
- States: IDLE, GRANT, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, READ, RESP.
- IDLE:
  - If any req_valid is set, pick a port.
  - If both are set, take the rr-pointer port, else the single requester. Go to GRANT.
- GRANT (1 cycle):
  - req_ready[g]=1; latch req_key, req_block, req_enc_dec and g into internal registers.
  - Drive key/plain/enc_dec from the latched values; they stay stable until RESP exits.
  - Next state is KEY_REQ, or DATA_REQ when the optional feature elides the key load.
- KEY_REQ:
  - newKey=1 until ldKey is sampled high. Drop newKey the cycle after, then go to KEY_WAIT.
- KEY_WAIT:
  - Wait for doneKey=1, then set key_owner=g, key_owner_valid=1, go to DATA_REQ.
- DATA_REQ:
  - newData=1 until ldData is sampled high. Drop newData, then go to DATA_WAIT.
- DATA_WAIT:
  - On doneData=1, register cipher into rsp_data, assert readData, go to READ.
- READ:
  - Hold readData=1 until doneData is sampled low, then readData=0 and go to RESP.
- RESP:
  - rsp_valid[g]=1 with rsp_data stable until rsp_ready[g]=1.
  - Then rsp_valid=0, rr pointer=~g, go to IDLE.
  - rsp_ready on the non-granted port is ignored.
- Simultaneous events:
  - A new req_valid arriving during any non-IDLE state waits; req_ready is never asserted outside GRANT.
  - The rr pointer only updates on RESP exit.
- Latency:
  - Accept to rsp_valid = 1 (GRANT) + key load + core rounds + 2 handshake cycles, with no idle cycles inserted by this block.
- At most one of newKey/newData is asserted at any time; key is always fully loaded before data is issued.
- req_valid dropped before grant: request withdrawn, no effect.

Optional Feature:
- Macro: SIMON_KEY_REUSE_EN.
- Defined: GRANT compares the latched key with the last loaded key register. If key_owner_valid=1 and the keys are equal, skip KEY_REQ/KEY_WAIT and go straight to DATA_REQ.
- Not defined: every grant performs a full key load. The last-key register and comparator are absent; key_owner_valid is still maintained.

Test Plan:
1. Reset, then port0 encrypt, key=0x1918111009080100, block=0x65656877 → one req_ready[0] pulse, newKey held until ldKey, then newData; rsp_valid[0] with rsp_data=0xC69BE9BB.
2. Port1 decrypt, same key, block=0xC69BE9BB → rsp_data=0x65656877 on rsp_valid[1].
   - Key reloaded without SIMON_KEY_REUSE_EN; newKey never asserted with it.
3. Both ports valid in the same cycle from reset → port0 served first, port1 second; third back-to-back request from both → port0 again (rr alternation).
4. Hold rsp_ready[0]=0 for 20 cycles → rsp_valid[0] and rsp_data stay 0xC69BE9BB; port1 request is not granted until rsp_ready[0]=1.
5. Assert R for 1 cycle during DATA_WAIT → next cycle all outputs 0, busy=0, state IDLE. A fresh request then completes correctly, including a key reload even with reuse enabled.
6. Check doneData-low timing: hold doneData high 3 cycles after readData → readData stays high exactly until doneData is sampled low, and rsp_valid rises the following cycle.
